// File: rtl/gpio_led_pkg.sv
// Shared definitions for the LED/GPIO output stage: channel mode encoding.
package gpio_led_pkg;

    localparam int unsigned MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_OFF    = 2'd0;
    localparam logic [MODE_W-1:0] MODE_DIRECT = 2'd1;
    localparam logic [MODE_W-1:0] MODE_PWM    = 2'd2;
    localparam logic [MODE_W-1:0] MODE_BLINK  = 2'd3;

endpackage

// File: rtl/gpio_led_chan.sv
// One LED channel: mode/duty/period registers, blink state and the logical-level mux.
module gpio_led_chan
    import gpio_led_pkg::*;
#(
    parameter int unsigned PWM_W   = 8,
    parameter int unsigned BLINK_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [MODE_W-1:0]  wr_mode,
    input  logic [PWM_W-1:0]   wr_duty,
    input  logic [BLINK_W-1:0] wr_period,
    input  logic               gpio,
    input  logic [PWM_W-1:0]   pwm_cnt,
    input  logic               frame,
    input  logic               force_on,
    output logic               lv
);

    logic [MODE_W-1:0]  mode_q, mode_d;
    logic [PWM_W-1:0]   duty_q, duty_d;
    logic [BLINK_W-1:0] period_q, period_d;
    logic [BLINK_W-1:0] bcnt_q, bcnt_d;
    logic               phase_q, phase_d;
    logic               pwm_on;

    always_comb begin
        mode_d   = mode_q;
        duty_d   = duty_q;
        period_d = period_q;
        bcnt_d   = bcnt_q;
        phase_d  = phase_q;
        if (frame) begin
            if (bcnt_q == period_q) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + BLINK_W'(1);
            end
        end
        // A config write restarts the blink sequence even on a frame cycle.
        if (wr_en) begin
            mode_d   = wr_mode;
            duty_d   = wr_duty;
            period_d = wr_period;
            bcnt_d   = '0;
            phase_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= MODE_DIRECT;
            duty_q   <= '1;
            period_q <= '0;
            bcnt_q   <= '0;
            phase_q  <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            duty_q   <= duty_d;
            period_q <= period_d;
            bcnt_q   <= bcnt_d;
            phase_q  <= phase_d;
        end
    end

    // Full-scale duty must stay lit through the pwm_cnt==max slot.
    assign pwm_on = (duty_q == '1) || (pwm_cnt < duty_q);

    always_comb begin
        lv = 1'b0;
        if (force_on) begin
            lv = 1'b1;
        end else begin
            case (mode_q)
                MODE_OFF:    lv = 1'b0;
                MODE_DIRECT: lv = gpio;
                MODE_PWM:    lv = gpio & pwm_on;
                MODE_BLINK:  lv = phase_q;
                default:     lv = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/gpio_led_ctrl.sv
// LED/GPIO output stage: shared prescaler, PWM counter, trap indicator and config port,
// driving N_CH per-channel mode muxes into registered, polarity-corrected pins.
module gpio_led_ctrl
    import gpio_led_pkg::*;
#(
    parameter int unsigned     N_CH      = 5,
    parameter logic [N_CH-1:0] ACT_LOW   = 5'b01100,
    parameter int unsigned     PWM_W     = 8,
    parameter int unsigned     BLINK_W   = 8,
    parameter int unsigned     PRESC_DIV = 125,
    parameter int unsigned     TRAP_CH   = 4,
    localparam int unsigned    CHW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [N_CH-1:0]    gpio_i,
    input  logic               trap_i,
    input  logic               cfg_valid_i,
    output logic               cfg_ready_o,
    input  logic [CHW-1:0]     cfg_ch_i,
    input  logic [MODE_W-1:0]  cfg_mode_i,
    input  logic [PWM_W-1:0]   cfg_duty_i,
    input  logic [BLINK_W-1:0] cfg_period_i,
    output logic               cfg_err_o,
    output logic [N_CH-1:0]    led_o
);

    localparam int unsigned PRESC_W = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PWM_W-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic               trap_seen_q, trap_seen_d;
    logic               ready_q, ready_d;
    logic               err_q, err_d;
    logic [N_CH-1:0]    led_q, led_d;
    logic [N_CH-1:0]    lv;
    logic               tick;
    logic               frame;
    logic               accept;
    logic               ch_valid;

    assign tick     = (presc_q == PRESC_W'(PRESC_DIV - 1));
    assign frame    = tick && (pwm_cnt_q == '1);
    assign accept   = cfg_valid_i && ready_q;
    assign ch_valid = 32'(cfg_ch_i) < N_CH;

    always_comb begin
        presc_d     = tick ? '0 : presc_q + PRESC_W'(1);
        pwm_cnt_d   = tick ? pwm_cnt_q + PWM_W'(1) : pwm_cnt_q;
        trap_seen_d = trap_seen_q | trap_i;
        // Ready drops for one cycle after every accept, limiting writes to one per two clocks.
        ready_d     = ~accept;
        err_d       = accept & ~ch_valid;
        led_d       = lv ^ ACT_LOW;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            presc_q     <= '0;
            pwm_cnt_q   <= '0;
            trap_seen_q <= 1'b0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            led_q       <= ACT_LOW;
        end else begin
            presc_q     <= presc_d;
            pwm_cnt_q   <= pwm_cnt_d;
            trap_seen_q <= trap_seen_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
            led_q       <= led_d;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_chan
        gpio_led_chan #(
            .PWM_W   (PWM_W),
            .BLINK_W (BLINK_W)
        ) u_chan (
            .clk       (clk_i),
            .rst_n     (rst_n_i),
            .wr_en     (accept && (cfg_ch_i == CHW'(c))),
            .wr_mode   (cfg_mode_i),
            .wr_duty   (cfg_duty_i),
            .wr_period (cfg_period_i),
            .gpio      (gpio_i[c]),
            .pwm_cnt   (pwm_cnt_q),
            .frame     (frame),
            .force_on  (trap_seen_q && (c == TRAP_CH)),
            .lv        (lv[c])
        );
    end

    assign cfg_ready_o = ready_q;
    assign cfg_err_o   = err_q;
    assign led_o       = led_q;

endmodule

// File: tb/tb_gpio_led_ctrl.sv
// Self-checking bench for gpio_led_ctrl: directed scenarios plus random traffic,
// compared every cycle against an arithmetic reference model.
module tb_gpio_led_ctrl;
    import gpio_led_pkg::*;

    localparam int unsigned NCH        = 5;
    localparam int unsigned PD         = 4;
    localparam int          FRAME_CLKS = PD * 256;
    localparam logic [NCH-1:0] ACTL    = 5'b01100;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] gpio;
    logic           trap;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [2:0]     cfg_ch;
    logic [1:0]     cfg_mode;
    logic [7:0]     cfg_duty;
    logic [7:0]     cfg_period;
    logic           cfg_err;
    logic [NCH-1:0] led;

    always #5 clk = ~clk;

    gpio_led_ctrl #(
        .N_CH      (NCH),
        .ACT_LOW   (ACTL),
        .PWM_W     (8),
        .BLINK_W   (8),
        .PRESC_DIV (PD),
        .TRAP_CH   (4)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .gpio_i       (gpio),
        .trap_i       (trap),
        .cfg_valid_i  (cfg_valid),
        .cfg_ready_o  (cfg_ready),
        .cfg_ch_i     (cfg_ch),
        .cfg_mode_i   (cfg_mode),
        .cfg_duty_i   (cfg_duty),
        .cfg_period_i (cfg_period),
        .cfg_err_o    (cfg_err),
        .led_o        (led)
    );

    int checks = 0;
    int errors = 0;
    int cycnt  = 0;

    // Reference model: k = clock edges since reset release; fsw = frames since last write.
    int             k;
    int             m_mode [NCH];
    int             m_duty [NCH];
    int             m_per  [NCH];
    int             fsw    [NCH];
    bit             m_trap;
    bit             m_ready;
    bit             m_err;
    logic [NCH-1:0] exp_led;
    logic [NCH-1:0] gpio_rmask;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        k = 0;
        for (int c = 0; c < NCH; c++) begin
            m_mode[c] = 1;
            m_duty[c] = 255;
            m_per[c]  = 0;
            fsw[c]    = 0;
        end
        m_trap  = 1'b0;
        m_ready = 1'b0;
        m_err   = 1'b0;
        exp_led = ACTL;
    endfunction

    function automatic void model_edge();
        int             pwm;
        bit             frm;
        bit             acc;
        logic [NCH-1:0] lv;
        if (rst_n !== 1'b1) begin
            model_reset();
            return;
        end
        pwm = (k / PD) % 256;
        frm = (k % FRAME_CLKS) == FRAME_CLKS - 1;
        for (int c = 0; c < NCH; c++) begin
            case (m_mode[c])
                0:       lv[c] = 1'b0;
                1:       lv[c] = gpio[c];
                2:       lv[c] = gpio[c] & ((m_duty[c] == 255) || (pwm < m_duty[c]));
                default: lv[c] = ((fsw[c] / (m_per[c] + 1)) % 2) == 1;
            endcase
            if (m_trap && c == 4) lv[c] = 1'b1;
        end
        acc     = cfg_valid && m_ready;
        m_err   = acc && (cfg_ch >= NCH);
        m_ready = !acc;
        if (frm) for (int c = 0; c < NCH; c++) fsw[c]++;
        if (acc && cfg_ch < NCH) begin
            m_mode[cfg_ch] = int'(cfg_mode);
            m_duty[cfg_ch] = int'(cfg_duty);
            m_per[cfg_ch]  = int'(cfg_period);
            fsw[cfg_ch]    = 0;
        end
        if (trap) m_trap = 1'b1;
        exp_led = lv ^ ACTL;
        k++;
    endfunction

    // Inputs are applied at the falling edge; outputs are checked at the next falling edge.
    task automatic cyc();
        gpio = (gpio & ~gpio_rmask) | (NCH'($urandom) & gpio_rmask);
        model_edge();
        @(posedge clk);
        @(negedge clk);
        cycnt++;
        chk("led_o", 32'(led), 32'(exp_led));
        chk("cfg_ready_o", 32'(cfg_ready), 32'(m_ready));
        chk("cfg_err_o", 32'(cfg_err), 32'(m_err));
    endtask

    task automatic cfg_write(input logic [2:0] ch, input logic [1:0] mode,
                             input logic [7:0] duty, input logic [7:0] per);
        bit acc_seen;
        acc_seen   = 1'b0;
        cfg_valid  = 1'b1;
        cfg_ch     = ch;
        cfg_mode   = mode;
        cfg_duty   = duty;
        cfg_period = per;
        for (int n = 0; n < 4 && !acc_seen; n++) begin
            acc_seen = cfg_ready;
            cyc();
        end
        cfg_valid = 1'b0;
        chk("cfg_accept", 32'(acc_seen), 32'd1);
    endtask

    task automatic count_on0(input int n, output int on_cnt);
        on_cnt = 0;
        for (int i = 0; i < n; i++) begin
            cyc();
            on_cnt += int'(led[0]);
        end
    endtask

    task automatic wait_toggle(input int bitn, input int limit, output int t);
        logic prev;
        bit   seen;
        seen = 1'b0;
        t    = 0;
        for (int n = 0; n < limit && !seen; n++) begin
            prev = led[bitn];
            cyc();
            if (led[bitn] !== prev) begin
                seen = 1'b1;
                t    = cycnt;
            end
        end
        chk("blink_toggle_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        int on_cnt;
        int t0;
        int t1;
        int t2;
        int n;
        bit acc;

        rst_n      = 1'b0;
        gpio       = '0;
        trap       = 1'b0;
        cfg_valid  = 1'b0;
        cfg_ch     = '0;
        cfg_mode   = '0;
        cfg_duty   = '0;
        cfg_period = '0;
        gpio_rmask = '0;
        model_reset();

        // Reset and release
        @(negedge clk);
        repeat (3) cyc();
        chk("reset_led", 32'(led), 32'(ACTL));
        chk("reset_ready_low", 32'(cfg_ready), 32'd0);
        rst_n = 1'b1;
        cyc();
        chk("ready_after_release", 32'(cfg_ready), 32'd1);
        chk("led_after_release", 32'(led), 32'(ACTL));

        // DIRECT latency
        gpio = 5'b00101;
        cyc();
        chk("direct_latency", 32'(led), 32'(5'b01001));

        // PWM duty sweep on channel 0
        gpio       = 5'b00001;
        gpio_rmask = 5'b11110;
        cfg_write(3'd0, MODE_PWM, 8'd64, 8'd0);
        repeat (2) cyc();
        count_on0(FRAME_CLKS, on_cnt);
        chk("pwm_duty64_on", 32'(on_cnt), 32'd256);
        cfg_write(3'd0, MODE_PWM, 8'd255, 8'd0);
        repeat (2) cyc();
        count_on0(FRAME_CLKS, on_cnt);
        chk("pwm_duty255_on", 32'(on_cnt), 32'd1024);
        cfg_write(3'd0, MODE_PWM, 8'd0, 8'd0);
        repeat (2) cyc();
        count_on0(FRAME_CLKS, on_cnt);
        chk("pwm_duty0_on", 32'(on_cnt), 32'd0);

        // BLINK on channel 1, period 2 -> toggle every 3 frames
        gpio_rmask = 5'b11111;
        cfg_write(3'd1, MODE_BLINK, 8'd0, 8'd2);
        t0 = cycnt;
        wait_toggle(1, 3200, t1);
        wait_toggle(1, 3200, t2);
        chk("blink_first_window", 32'((t1 - t0 > 2048) && (t1 - t0 <= 3073)), 32'd1);
        chk("blink_interval", 32'(t2 - t1), 32'd3072);

        // Random config traffic
        for (int i = 0; i < 4000; i++) begin
            cfg_valid  = ($urandom_range(0, 5) == 0);
            cfg_ch     = 3'($urandom_range(0, 7));
            cfg_mode   = 2'($urandom);
            case ($urandom_range(0, 3))
                0:       cfg_duty = 8'd0;
                1:       cfg_duty = 8'd255;
                default: cfg_duty = 8'($urandom);
            endcase
            cfg_period = 8'($urandom_range(0, 3));
            cyc();
        end
        cfg_valid = 1'b0;
        cyc();

        // Invalid channel
        cfg_write(3'd7, MODE_OFF, 8'd0, 8'd0);
        chk("cfg_err_pulse", 32'(cfg_err), 32'd1);
        cyc();
        chk("cfg_err_single", 32'(cfg_err), 32'd0);

        // Back-to-back writes
        for (int w = 0; w < 4 && !cfg_ready; w++) cyc();
        cfg_valid  = 1'b1;
        cfg_ch     = 3'd2;
        cfg_mode   = MODE_DIRECT;
        cfg_duty   = 8'd255;
        cfg_period = 8'd0;
        cyc();
        cfg_ch   = 3'd3;
        cfg_mode = MODE_PWM;
        cfg_duty = 8'd128;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 4) begin
            acc = cfg_ready;
            cyc();
            n++;
        end
        cfg_valid = 1'b0;
        chk("b2b_second_gap", 32'(n), 32'd2);

        // Trap override
        cfg_write(3'd1, MODE_BLINK, 8'd0, 8'd0);
        trap = 1'b1;
        cyc();
        trap = 1'b0;
        cyc();
        chk("trap_override", 32'(led[4]), 32'd1);
        cfg_write(3'd4, MODE_OFF, 8'd0, 8'd0);
        repeat (3) cyc();
        chk("trap_beats_off", 32'(led[4]), 32'd1);

        // Asynchronous reset in the middle of a blink
        wait_toggle(1, 1100, t1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_led", 32'(led), 32'(ACTL));
        chk("async_reset_ready", 32'(cfg_ready), 32'd0);
        model_reset();
        @(negedge clk);
        gpio_rmask = '0;
        gpio       = '0;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        chk("trap_cleared", 32'(led[4]), 32'd0);
        chk("ready_after_abort", 32'(cfg_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
